// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//
// Round-robin arbiter that shares one synchronous FIFO write port among NREQ
// producers. Each grant lasts up to BURST_LEN accepted beats. The arbiter
// drives the FIFO write enable and data directly. It stalls on FIFO full
// without dropping or repeating a word.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req           per-requester write request, held while data is pending
//   req_data      requester i data in [i*WIDTH +: WIDTH]
//   ack           one-hot, beat taken from requester i this cycle
//   gnt           one-hot registered grant, or all-zero
//   fifo_full     FIFO full flag
//   fifo_w_en     FIFO write enable
//   fifo_in_data  FIFO write data
//   owner         index of the granted requester, valid while busy
//   busy          high while a burst is granted
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no grant; waiting for any request
// BURST  | port granted to owner; beats accepted while req and !full

module fifo_write_arbiter #(
  parameter int WIDTH     = 4,
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         gnt,
  input  logic                    fifo_full,
  output logic                    fifo_w_en,
  output logic [WIDTH-1:0]        fifo_in_data,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_owner_q, last_owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_burst;
  logic             accept;
  logic             burst_end;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;

  assign in_burst  = (state_q == ST_BURST);
  assign accept    = in_burst && req[owner_q] && !fifo_full;
  // A burst closes on its last accepted beat, or as soon as the owner
  // withdraws its request.
  assign burst_end = in_burst && (!req[owner_q] || (accept && (cnt_q == CNT_LAST)));

  // Round-robin pick. Walk from the farthest candidate back to the nearest,
  // so the nearest asserted request after last_owner overwrites the others.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_owner_q) + k) % NREQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= IDX_LAST;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d      = ST_BURST;
          owner_d      = pick_idx;
          last_owner_d = pick_idx;
          cnt_d        = '0;
        end
      end
      ST_BURST: begin
        if (burst_end) begin
          // Hand over in the same edge so there is no idle cycle between
          // bursts. The old owner is still a candidate, but it is checked last.
          if (pick_valid) begin
            owner_d      = pick_idx;
            last_owner_d = pick_idx;
            cnt_d        = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_in_data = '0;
    if (in_burst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (owner_q == IDX_W'(i)) fifo_in_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign busy      = in_burst;
  assign owner     = owner_q;
  assign gnt       = in_burst ? (NREQ'(1) << owner_q) : '0;
  assign ack       = accept ? gnt : '0;
  assign fifo_w_en = accept;

endmodule
